// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: forwarding
// select encodings, FSM states and per-stage shadow records.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_MEM_WAIT = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_shadow_t;

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [4:0] dest;
  } mem_shadow_t;

  typedef struct packed {
    logic       vld;
    logic       rw;
    logic [4:0] dest;
  } wb_shadow_t;

  // A stage forwards only a real register write to the operand's register.
  function automatic logic fwd_hit(input logic vld, input logic rw,
                                   input logic [4:0] dest, input logic [4:0] src);
    return vld && rw && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage forwarding compare; one select per source operand,
// MEM result preferred over WB result.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int NUM_OPS = 2
) (
  input  logic [NUM_OPS-1:0][4:0] src,
  input  logic                    mem_vld,
  input  logic                    mem_rw,
  input  logic [4:0]              mem_dest,
  input  logic                    wb_vld,
  input  logic                    wb_rw,
  input  logic [4:0]              wb_dest,
  output logic [NUM_OPS-1:0][1:0] sel
);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    logic hit_mem, hit_wb;
    assign hit_mem = fwd_hit(mem_vld, mem_rw, mem_dest, src[g]);
    assign hit_wb  = fwd_hit(wb_vld, wb_rw, wb_dest, src[g]);
    assign sel[g]  = hit_mem ? FWD_MEM : (hit_wb ? FWD_WB : FWD_RF);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: memory freeze,
// taken-branch squash, load-use bubble, and EX-stage forwarding selects.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       idRs_i,
  input  logic [4:0]       idRt_i,
  input  logic             idUsesRt_i,
  input  logic [4:0]       idDest_i,
  input  logic             idRegWrite_i,
  input  logic             idMemRead_i,
  input  logic             idMemWrite_i,
  input  logic             exBranchTaken_i,
  input  logic             dmemReady_i,
  output logic             pcEn_o,
  output logic             fdEn_o,
  output logic             deEn_o,
  output logic             emEn_o,
  output logic             mwEn_o,
  output logic             fdFlush_o,
  output logic             deFlush_o,
  output logic [1:0]       fwdA_o,
  output logic [1:0]       fwdB_o,
  output logic [CNT_W-1:0] stallCnt_o
);

  hz_state_e        state_q;
  ex_shadow_t       ex_q;
  mem_shadow_t      mem_q;
  wb_shadow_t       wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic freeze, load_use;
  logic pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush;
  logic [1:0][1:0] fwd_sel;

  assign freeze = mem_q.vld && (mem_q.mr || mem_q.mw) && !dmemReady_i;

  // In STALL the EX slot holds the bubble we just inserted, so no re-detection.
  assign load_use = (state_q != ST_STALL) && ex_q.vld && ex_q.mr &&
                    (ex_q.dest != REG_ZERO) &&
                    ((ex_q.dest == idRs_i) || (idUsesRt_i && (ex_q.dest == idRt_i)));

  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    if (freeze) begin
      // Whole pipe holds; a pending branch or load-use stays put and fires on exit.
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (exBranchTaken_i) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (load_use) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
    end else if (freeze) begin
      state_q <= ST_MEM_WAIT;
    end else if (!exBranchTaken_i && load_use) begin
      state_q <= ST_STALL;
    end else begin
      state_q <= ST_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      if (de_en) begin
        if (de_flush) ex_q <= '0;
        else ex_q <= '{vld: 1'b1, rw: idRegWrite_i, mr: idMemRead_i, mw: idMemWrite_i,
                       dest: idDest_i, rs: idRs_i, rt: idRt_i};
      end
      if (em_en) begin
        mem_q <= '{vld: ex_q.vld, rw: ex_q.rw, mr: ex_q.mr, mw: ex_q.mw, dest: ex_q.dest};
      end
      if (mw_en) begin
        wb_q <= '{vld: mem_q.vld, rw: mem_q.rw, dest: mem_q.dest};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!pc_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  fwd_unit #(.NUM_OPS(2)) u_fwd (
    .src      ({ex_q.rt, ex_q.rs}),
    .mem_vld  (mem_q.vld),
    .mem_rw   (mem_q.rw),
    .mem_dest (mem_q.dest),
    .wb_vld   (wb_q.vld),
    .wb_rw    (wb_q.rw),
    .wb_dest  (wb_q.dest),
    .sel      (fwd_sel)
  );

  assign pcEn_o     = pc_en;
  assign fdEn_o     = fd_en;
  assign deEn_o     = de_en;
  assign emEn_o     = em_en;
  assign mwEn_o     = mw_en;
  assign fdFlush_o  = fd_flush;
  assign deFlush_o  = de_flush;
  assign fwdA_o     = fwd_sel[0];
  assign fwdB_o     = fwd_sel[1];
  assign stallCnt_o = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// expectations into a queue, a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [4:0]  idRs_i = '0, idRt_i = '0, idDest_i = '0;
  logic        idUsesRt_i = 1'b0, idRegWrite_i = 1'b0, idMemRead_i = 1'b0, idMemWrite_i = 1'b0;
  logic        exBranchTaken_i = 1'b0;
  logic        dmemReady_i = 1'b1;
  logic        pcEn_o, fdEn_o, deEn_o, emEn_o, mwEn_o, fdFlush_o, deFlush_o;
  logic [1:0]  fwdA_o, fwdB_o;
  logic [15:0] stallCnt_o;

  pipeline_hazard_ctrl #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .idRs_i(idRs_i), .idRt_i(idRt_i), .idUsesRt_i(idUsesRt_i), .idDest_i(idDest_i),
    .idRegWrite_i(idRegWrite_i), .idMemRead_i(idMemRead_i), .idMemWrite_i(idMemWrite_i),
    .exBranchTaken_i(exBranchTaken_i), .dmemReady_i(dmemReady_i),
    .pcEn_o(pcEn_o), .fdEn_o(fdEn_o), .deEn_o(deEn_o), .emEn_o(emEn_o), .mwEn_o(mwEn_o),
    .fdFlush_o(fdFlush_o), .deFlush_o(deFlush_o),
    .fwdA_o(fwdA_o), .fwdB_o(fwdB_o), .stallCnt_o(stallCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [4:0]  en;   // {pc, fd, de, em, mw}
    logic [1:0]  fl;   // {fdFlush, deFlush}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] FRZ = 5'b00000;
  localparam logic [4:0] LUE = 5'b00111;

  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                    input logic [4:0] d, input logic rw, input logic mr, input logic mw);
    idRs_i = rs; idRt_i = rt; idUsesRt_i = ur; idDest_i = d;
    idRegWrite_i = rw; idMemRead_i = mr; idMemWrite_i = mw;
  endtask

  task automatic cyc(input string n, input logic [4:0] en, input logic [1:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic [15:0] cnt);
    exp_t e;
    e.name = n; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (sb.size() != 0) begin
      m_e = sb.pop_front();
      checks++;
      if ({pcEn_o, fdEn_o, deEn_o, emEn_o, mwEn_o} !== m_e.en ||
          {fdFlush_o, deFlush_o} !== m_e.fl || fwdA_o !== m_e.fa ||
          fwdB_o !== m_e.fb || stallCnt_o !== m_e.cnt) begin
        errors++;
        $display("FAIL %s: got en=%b fl=%b fwdA=%b fwdB=%b cnt=%0d, want en=%b fl=%b fwdA=%b fwdB=%b cnt=%0d",
                 m_e.name, {pcEn_o, fdEn_o, deEn_o, emEn_o, mwEn_o}, {fdFlush_o, deFlush_o},
                 fwdA_o, fwdB_o, stallCnt_o, m_e.en, m_e.fl, m_e.fa, m_e.fb, m_e.cnt);
      end
    end
  end

  initial begin
    @(posedge clk_i); #1;
    cyc("reset", ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    rst_ni = 1'b1;

    // forwarding: add $3 twice, then sub $4,$3,$3; writes to $0
    id(1, 2, 1, 3, 1, 0, 0);  cyc("fwd_idle",         ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(1, 2, 1, 3, 1, 0, 0);  cyc("fwd_ex_only",      ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(3, 3, 1, 4, 1, 0, 0);  cyc("fwd_nomatch",      ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(5, 6, 1, 0, 1, 0, 0);  cyc("fwd_mem_beats_wb", ALL, 2'b00, 2'b01, 2'b01, 16'd0);
    id(0, 0, 1, 7, 1, 0, 0);  cyc("fwd_other",        ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("fwd_zero_dest",    ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(7, 4, 1, 9, 1, 0, 0);  cyc("fwd_nop_ex",       ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("fwd_wb",           ALL, 2'b00, 2'b10, 2'b00, 16'd0);

    // load-use: lw $8 then add $10,$8,$2
    id(1, 8, 0, 8, 1, 1, 0);  cyc("lw_issue",         ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(8, 2, 1, 10, 1, 0, 0); cyc("load_use",         LUE, 2'b01, 2'b00, 2'b00, 16'd0);
                              cyc("stall_cycle",      ALL, 2'b00, 2'b00, 2'b00, 16'd1);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("lu_fwd_wb",        ALL, 2'b00, 2'b10, 2'b00, 16'd1);

    // taken branch with a load-use pattern in the same cycle
    id(1, 11, 0, 11, 1, 1, 0); cyc("lw2_issue",       ALL, 2'b00, 2'b00, 2'b00, 16'd1);
    id(11, 11, 1, 12, 1, 0, 0); exBranchTaken_i = 1'b1;
                              cyc("branch_flush",     ALL, 2'b11, 2'b00, 2'b00, 16'd1);
    exBranchTaken_i = 1'b0; id(0, 0, 0, 0, 0, 0, 0);
                              cyc("branch_bubble",    ALL, 2'b00, 2'b00, 2'b00, 16'd1);

    // memory wait: lw in MEM with dmemReady low for 3 cycles
    id(1, 13, 0, 13, 1, 1, 0); cyc("lw3_issue",       ALL, 2'b00, 2'b00, 2'b00, 16'd1);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("lw3_ex",           ALL, 2'b00, 2'b00, 2'b00, 16'd1);
    dmemReady_i = 1'b0;       cyc("mem_wait1",        FRZ, 2'b00, 2'b00, 2'b00, 16'd1);
                              cyc("mem_wait2",        FRZ, 2'b00, 2'b00, 2'b00, 16'd2);
                              cyc("mem_wait3",        FRZ, 2'b00, 2'b00, 2'b00, 16'd3);
    dmemReady_i = 1'b1;       cyc("mem_wait_exit",    ALL, 2'b00, 2'b00, 2'b00, 16'd4);

    // branch while a store in MEM is frozen
    id(1, 5, 1, 0, 0, 0, 1);  cyc("sw_issue",         ALL, 2'b00, 2'b00, 2'b00, 16'd4);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("sw_ex",            ALL, 2'b00, 2'b00, 2'b00, 16'd4);
    id(2, 3, 1, 6, 1, 0, 0); exBranchTaken_i = 1'b1; dmemReady_i = 1'b0;
                              cyc("br_frozen1",       FRZ, 2'b00, 2'b00, 2'b00, 16'd4);
                              cyc("br_frozen2",       FRZ, 2'b00, 2'b00, 2'b00, 16'd5);
    dmemReady_i = 1'b1;       cyc("br_after_freeze",  ALL, 2'b11, 2'b00, 2'b00, 16'd6);
    exBranchTaken_i = 1'b0; id(0, 0, 0, 0, 0, 0, 0);
                              cyc("br_after_bubble",  ALL, 2'b00, 2'b00, 2'b00, 16'd6);

    // load-use bubble followed by a freeze on the load
    id(1, 14, 0, 14, 1, 1, 0); cyc("lw4_issue",       ALL, 2'b00, 2'b00, 2'b00, 16'd6);
    id(14, 0, 1, 15, 1, 0, 0); cyc("lu_then_freeze",  LUE, 2'b01, 2'b00, 2'b00, 16'd6);
    dmemReady_i = 1'b0;       cyc("lu_frozen",        FRZ, 2'b00, 2'b00, 2'b00, 16'd7);
    dmemReady_i = 1'b1;       cyc("lu_freeze_done",   ALL, 2'b00, 2'b00, 2'b00, 16'd8);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("lu_freeze_fwd",    ALL, 2'b00, 2'b10, 2'b00, 16'd8);

    // reset dropped while in STALL
    id(1, 16, 0, 16, 1, 1, 0); cyc("lw5_issue",       ALL, 2'b00, 2'b00, 2'b00, 16'd8);
    id(16, 16, 1, 17, 1, 0, 0); cyc("lu_before_reset", LUE, 2'b01, 2'b00, 2'b00, 16'd8);
    rst_ni = 1'b0;            cyc("reset_mid_stall",  ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    rst_ni = 1'b1;            cyc("post_reset",       ALL, 2'b00, 2'b00, 2'b00, 16'd0);
    id(0, 0, 0, 0, 0, 0, 0);  cyc("shadow_invalid",   ALL, 2'b00, 2'b00, 2'b00, 16'd0);

    @(negedge clk_i); #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
